// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table response checker.
// Holds the FSM encoding, the mismatch counter width and the 3-input majority default table.
package tt_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } tt_state_t;

    localparam int MISMATCH_W = 8;

    localparam logic [7:0] MAJ3_TT = 8'b1110_1000;

    function automatic logic [MISMATCH_W-1:0] sat_inc(input logic [MISMATCH_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/tt_response_checker_if.sv
// Observation bus between a stimulus/DUT pair (master) and the truth-table checker (slave).
// Optional first-fail signals exist only when TT_FIRST_FAIL_EN is defined.
interface tt_response_checker_if #(parameter int N_IN = 3);
    import tt_pkg::*;

    localparam int TT_W = 1 << N_IN;

    logic                  start;
    logic [N_IN-1:0]       in_vec;
    logic                  y;
    logic                  busy;
    logic                  done;
    logic                  pass;
    logic [TT_W-1:0]       observed;
    logic [TT_W-1:0]       covered;
    logic [MISMATCH_W-1:0] mismatch_cnt;
    logic                  conflict;
    logic                  timed_out;
`ifdef TT_FIRST_FAIL_EN
    logic [N_IN-1:0]       first_fail_vec;
    logic                  first_fail_valid;

    modport master (
        output start, in_vec, y,
        input  busy, done, pass, observed, covered, mismatch_cnt, conflict, timed_out,
               first_fail_vec, first_fail_valid
    );
    modport slave (
        input  start, in_vec, y,
        output busy, done, pass, observed, covered, mismatch_cnt, conflict, timed_out,
               first_fail_vec, first_fail_valid
    );
`else
    modport master (
        output start, in_vec, y,
        input  busy, done, pass, observed, covered, mismatch_cnt, conflict, timed_out
    );
    modport slave (
        input  start, in_vec, y,
        output busy, done, pass, observed, covered, mismatch_cnt, conflict, timed_out
    );
`endif

endinterface

// File: rtl/tt_stability_filter.sv
// Stability filter: one combinational strobe per stable window of in_vec.
// Latency: a vector first seen in cycle t strobes in cycle t+SETTLE; no backpressure, runs every cycle.
// Backpressure: none; clr restarts the stability count without touching prev_vec.
module tt_stability_filter #(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clr,
    input  logic [N_IN-1:0] in_vec,
    output logic            strobe
);

    localparam int STAB_W = $clog2(SETTLE + 1);
    localparam logic [STAB_W-1:0] STAB_SAT = STAB_W'(SETTLE);
    localparam logic [STAB_W-1:0] STAB_ARM = STAB_W'(SETTLE - 1);

    logic [N_IN-1:0]   prev_vec;
    logic [STAB_W-1:0] stab_cnt;
    logic              same;

    assign same   = (in_vec == prev_vec);
    // Only the SETTLE-1 -> SETTLE step fires; the saturated count keeps a long hold to one sample.
    assign strobe = same && (stab_cnt == STAB_ARM);

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_vec <= '0;
            stab_cnt <= '0;
        end else begin
            prev_vec <= in_vec;
            if (clr || !same) begin
                stab_cnt <= '0;
            end else if (stab_cnt != STAB_SAT) begin
                stab_cnt <= stab_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/tt_response_checker.sv
// Truth-table response checker: samples y per settled input vector, compares the table with EXP_TT.
// Latency: sample SETTLE cycles after a vector change; done/pass one edge after coverage completes.
// Backpressure: none; start is ignored in CAPTURE. TT_FIRST_FAIL_EN adds first-fail capture.
module tt_response_checker
    import tt_pkg::*;
#(
    parameter int                      N_IN    = 3,
    parameter int                      SETTLE  = 2,
    parameter int                      TIMEOUT = 255,
    parameter logic [(1 << N_IN)-1:0]  EXP_TT  = MAJ3_TT
) (
    input  logic                 clk,
    input  logic                 rst,
    tt_response_checker_if.slave bus
);

    localparam int TT_W = 1 << N_IN;
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    tt_state_t             state;
    logic                  busy_q, done_q, pass_q;
    logic [TT_W-1:0]       observed_q, observed_nxt;
    logic [TT_W-1:0]       covered_q, covered_nxt;
    logic [MISMATCH_W-1:0] mm_q, mm_nxt;
    logic                  conflict_q, conflict_nxt;
    logic                  timed_out_q;
    logic                  pass_nxt;
    logic [15:0]           tmo_cnt;
    logic                  strobe, sample, run_start, bit_mis;
`ifdef TT_FIRST_FAIL_EN
    logic [N_IN-1:0]       ff_vec_q, ff_vec_nxt;
    logic                  ff_valid_q, ff_valid_nxt;
`endif

    assign run_start = bus.start && (state != CAPTURE);
    assign sample    = strobe && (state == CAPTURE);
    assign bit_mis   = (bus.y != EXP_TT[bus.in_vec]);

    tt_stability_filter #(
        .N_IN   (N_IN),
        .SETTLE (SETTLE)
    ) u_filter (
        .clk    (clk),
        .rst    (rst),
        .clr    (run_start),
        .in_vec (bus.in_vec),
        .strobe (strobe)
    );

    always_comb begin
        observed_nxt = observed_q;
        covered_nxt  = covered_q;
        mm_nxt       = mm_q;
        conflict_nxt = conflict_q;
`ifdef TT_FIRST_FAIL_EN
        ff_vec_nxt   = ff_vec_q;
        ff_valid_nxt = ff_valid_q;
`endif
        if (sample) begin
            observed_nxt[bus.in_vec] = bus.y;
            covered_nxt[bus.in_vec]  = 1'b1;
            if (covered_q[bus.in_vec] && (observed_q[bus.in_vec] != bus.y)) begin
                conflict_nxt = 1'b1;
            end
            if (bit_mis) begin
                mm_nxt = sat_inc(mm_q);
`ifdef TT_FIRST_FAIL_EN
                if (!ff_valid_q) begin
                    ff_vec_nxt   = bus.in_vec;
                    ff_valid_nxt = 1'b1;
                end
`endif
            end
        end
        pass_nxt = (observed_nxt == EXP_TT) && !conflict_nxt && !timed_out_q && (mm_nxt == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            observed_q  <= '0;
            covered_q   <= '0;
            mm_q        <= '0;
            conflict_q  <= 1'b0;
            timed_out_q <= 1'b0;
            tmo_cnt     <= '0;
`ifdef TT_FIRST_FAIL_EN
            ff_vec_q    <= '0;
            ff_valid_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        state       <= CAPTURE;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        observed_q  <= '0;
                        covered_q   <= '0;
                        mm_q        <= '0;
                        conflict_q  <= 1'b0;
                        timed_out_q <= 1'b0;
                        tmo_cnt     <= '0;
`ifdef TT_FIRST_FAIL_EN
                        ff_vec_q    <= '0;
                        ff_valid_q  <= 1'b0;
`endif
                    end
                end
                CAPTURE: begin
                    observed_q <= observed_nxt;
                    covered_q  <= covered_nxt;
                    mm_q       <= mm_nxt;
                    conflict_q <= conflict_nxt;
`ifdef TT_FIRST_FAIL_EN
                    ff_vec_q   <= ff_vec_nxt;
                    ff_valid_q <= ff_valid_nxt;
`endif
                    if (tmo_cnt != 16'hFFFF) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                    // A sample completing coverage on the timeout edge defers the finish one cycle.
                    if (&covered_q) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        pass_q <= pass_nxt;
                    end else if ((tmo_cnt >= TMO_LAST) && !(&covered_nxt)) begin
                        state       <= DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        pass_q      <= 1'b0;
                        timed_out_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.pass         = pass_q;
    assign bus.observed     = observed_q;
    assign bus.covered      = covered_q;
    assign bus.mismatch_cnt = mm_q;
    assign bus.conflict     = conflict_q;
    assign bus.timed_out    = timed_out_q;
`ifdef TT_FIRST_FAIL_EN
    assign bus.first_fail_vec   = ff_vec_q;
    assign bus.first_fail_valid = ff_valid_q;
`endif

endmodule

// File: tb/tb_tt_response_checker.sv
// Directed bench for tt_response_checker with SETTLE=2, TIMEOUT=40 and the majority table.
module tb_tt_response_checker;

    logic clk;
    logic rst;
    int   tests;
    int   fails;

    tt_response_checker_if #(.N_IN(3)) bus ();

    tt_response_checker #(
        .N_IN    (3),
        .SETTLE  (2),
        .TIMEOUT (40),
        .EXP_TT  (8'b1110_1000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] vec;
        logic       y;
        logic [7:0] cov;
        logic [7:0] obs;
        logic [7:0] mm;
    } rec_t;

    rec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] v, input logic yy, input int n);
        bus.in_vec = v;
        bus.y      = yy;
        tick(n);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    function automatic logic maj(input logic [2:0] v);
        return (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
    endfunction

    task automatic rec(input int i, input logic [2:0] v, input logic yy,
                       input logic [7:0] c, input logic [7:0] o, input logic [7:0] m);
        tbl[i].vec = v;
        tbl[i].y   = yy;
        tbl[i].cov = c;
        tbl[i].obs = o;
        tbl[i].mm  = m;
    endtask

    task automatic run_table(input int first);
        pulse_start();
        chk("busy_after_start", 32'(bus.busy), 32'd1);
        chk("done_after_start", 32'(bus.done), 32'd0);
        for (int i = first; i < first + 8; i++) begin
            drive(tbl[i].vec, tbl[i].y, 4);
            chk($sformatf("covered[%0d]", i), 32'(bus.covered), 32'(tbl[i].cov));
            chk($sformatf("observed[%0d]", i), 32'(bus.observed), 32'(tbl[i].obs));
            chk($sformatf("mismatch[%0d]", i), 32'(bus.mismatch_cnt), 32'(tbl[i].mm));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
        chk({tag, "_done"}, 32'(bus.done), 32'd0);
        chk({tag, "_pass"}, 32'(bus.pass), 32'd0);
        chk({tag, "_observed"}, 32'(bus.observed), 32'd0);
        chk({tag, "_covered"}, 32'(bus.covered), 32'd0);
        chk({tag, "_mismatch"}, 32'(bus.mismatch_cnt), 32'd0);
        chk({tag, "_conflict"}, 32'(bus.conflict), 32'd0);
        chk({tag, "_timed_out"}, 32'(bus.timed_out), 32'd0);
`ifdef TT_FIRST_FAIL_EN
        chk({tag, "_ff_valid"}, 32'(bus.first_fail_valid), 32'd0);
        chk({tag, "_ff_vec"}, 32'(bus.first_fail_vec), 32'd0);
`endif
    endtask

    initial begin
        int n;
        tests = 0;
        fails = 0;

        // Clean majority run.
        rec(0, 3'd0, 1'b0, 8'h01, 8'h00, 8'd0);
        rec(1, 3'd1, 1'b0, 8'h03, 8'h00, 8'd0);
        rec(2, 3'd2, 1'b0, 8'h07, 8'h00, 8'd0);
        rec(3, 3'd3, 1'b1, 8'h0F, 8'h08, 8'd0);
        rec(4, 3'd4, 1'b0, 8'h1F, 8'h08, 8'd0);
        rec(5, 3'd5, 1'b1, 8'h3F, 8'h28, 8'd0);
        rec(6, 3'd6, 1'b1, 8'h7F, 8'h68, 8'd0);
        rec(7, 3'd7, 1'b1, 8'hFF, 8'hE8, 8'd0);
        // Same run with y stuck at 1 for index 1.
        rec(8,  3'd0, 1'b0, 8'h01, 8'h00, 8'd0);
        rec(9,  3'd1, 1'b1, 8'h03, 8'h02, 8'd1);
        rec(10, 3'd2, 1'b0, 8'h07, 8'h02, 8'd1);
        rec(11, 3'd3, 1'b1, 8'h0F, 8'h0A, 8'd1);
        rec(12, 3'd4, 1'b0, 8'h1F, 8'h0A, 8'd1);
        rec(13, 3'd5, 1'b1, 8'h3F, 8'h2A, 8'd1);
        rec(14, 3'd6, 1'b1, 8'h7F, 8'h6A, 8'd1);
        rec(15, 3'd7, 1'b1, 8'hFF, 8'hEA, 8'd1);

        rst        = 1'b1;
        bus.start  = 1'b0;
        bus.in_vec = 3'd0;
        bus.y      = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_all_zero("reset");

        run_table(0);
        chk("run1_done", 32'(bus.done), 32'd1);
        chk("run1_pass", 32'(bus.pass), 32'd1);
        chk("run1_busy", 32'(bus.busy), 32'd0);

        run_table(8);
        chk("run2_done", 32'(bus.done), 32'd1);
        chk("run2_pass", 32'(bus.pass), 32'd0);
`ifdef TT_FIRST_FAIL_EN
        chk("run2_ff_vec", 32'(bus.first_fail_vec), 32'd1);
        chk("run2_ff_valid", 32'(bus.first_fail_valid), 32'd1);
`endif

        // Glitch rejection and conflicting re-sample.
        pulse_start();
        drive(3'd5, 1'b1, 2);
        drive(3'd3, 1'b1, 1);
        chk("glitch_covered", 32'(bus.covered), 32'h00);
        drive(3'd5, 1'b1, 3);
        chk("hold3_covered", 32'(bus.covered), 32'h20);
        drive(3'd6, 1'b1, 3);
        chk("first6_observed", 32'(bus.observed), 32'h60);
        chk("first6_conflict", 32'(bus.conflict), 32'd0);
        drive(3'd0, 1'b0, 1);
        drive(3'd6, 1'b0, 3);
        chk("resample6_conflict", 32'(bus.conflict), 32'd1);
        chk("resample6_observed", 32'(bus.observed), 32'h20);
        chk("resample6_mismatch", 32'(bus.mismatch_cnt), 32'd1);
        foreach (tbl[i]) begin
            if (i < 8 && tbl[i].vec != 3'd5 && tbl[i].vec != 3'd6) begin
                drive(tbl[i].vec, maj(tbl[i].vec), 3);
            end
        end
        chk("conf_busy_before_done", 32'(bus.done), 32'd0);
        tick(1);
        chk("conf_done", 32'(bus.done), 32'd1);
        chk("conf_pass", 32'(bus.pass), 32'd0);
        chk("conf_covered", 32'(bus.covered), 32'hFF);
        chk("conf_observed", 32'(bus.observed), 32'hA8);

        // Timeout with index 7 never driven.
        pulse_start();
        n = 0;
        for (int v = 0; v < 7; v++) begin
            drive(3'(v), maj(3'(v)), 4);
            n += 4;
        end
        while (!bus.done && n < 60) begin
            tick(1);
            n++;
        end
        chk("timeout_cycles", 32'(n), 32'd40);
        chk("timeout_done", 32'(bus.done), 32'd1);
        chk("timeout_flag", 32'(bus.timed_out), 32'd1);
        chk("timeout_pass", 32'(bus.pass), 32'd0);
        chk("timeout_covered", 32'(bus.covered), 32'h7F);

        // Reset mid-run, then a clean run.
        pulse_start();
        for (int v = 0; v < 4; v++) begin
            drive(3'(v), maj(3'(v)), 4);
        end
        chk("midrun_covered", 32'(bus.covered), 32'h0F);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk_all_zero("midrun_reset");
        tick(2);
        chk("idle_busy", 32'(bus.busy), 32'd0);
        run_table(0);
        chk("post_reset_done", 32'(bus.done), 32'd1);
        chk("post_reset_pass", 32'(bus.pass), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tt_response_checker.md
# tt_response_checker

- Response-side counterpart to the team's exhaustive 3-input stimulus benches: watches the input vector {a,b,c} and response y of a combinational DUT, samples y once each vector has been stable long enough, and builds the observed truth table.
- When every input combination has been covered, compares the observed table against a parameterised expected table and reports pass/fail.
- Sits beside the DUT in simulation or on-chip self-test, with no coupling to the stimulus source.

## Interface
- N_IN, 3: number of DUT inputs; table depth is 2**N_IN.
- SETTLE, 2: cycles a vector must be held unchanged before y is sampled (>=1).
- TIMEOUT, 255: cycles allowed in CAPTURE before forced finish (<=2**16-1).
- EXP_TT, 8'b1110_1000: expected y for each index; default is 3-input majority.
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a capture run; ignored while in CAPTURE.
- in_vec  in  N_IN  DUT input vector; index = {a,b,c}, with a as MSB.
- y  in  1  DUT response.
- busy  out  1  high in CAPTURE.
- done  out  1  high in DONE, held until start or rst.
- pass  out  1  valid while done is high.
- observed  out  2**N_IN  sampled y per index.
- covered  out  2**N_IN  index has been sampled at least once.
- mismatch_cnt  out  8  saturating count of samples with y != EXP_TT[idx].
- conflict  out  1  sticky; an index was sampled twice with different y.
- timed_out  out  1  sticky; the run ended by timeout.

## Operation
- States: IDLE, CAPTURE, DONE.
  - IDLE -> CAPTURE on start.
  - CAPTURE -> DONE when covered becomes all-ones, or when the timeout counter reaches TIMEOUT.
  - DONE -> CAPTURE on start.
- Entering CAPTURE clears: observed, covered, mismatch_cnt, conflict, timed_out, the stability counter and the timeout counter.
- Stability tracking:
  - prev_vec is registered every cycle.
  - stab_cnt resets to 0 when in_vec != prev_vec; otherwise it increments, saturating at SETTLE.
  - The sample strobe fires on the single cycle where stab_cnt goes from SETTLE-1 to SETTLE, so each stable window produces exactly one sample.
- On the sample strobe, with idx = in_vec:
  - observed[idx] <= y and covered[idx] <= 1.
  - If covered[idx] was already 1 and observed[idx] != y, conflict <= 1.
  - If y != EXP_TT[idx], mismatch_cnt increments, saturating at 255.
- pass = (observed == EXP_TT) && !conflict && !timed_out && (mismatch_cnt == 0). It is registered on entry to DONE.
- Sampling and counting happen only in CAPTURE. The stability tracker runs in every state, but its strobe is gated.

## Timing
- Reset values: all outputs 0 and state IDLE. Reset clears a run in progress with no residue.
- start is registered: busy rises one cycle after start is sampled.
- Sample latency: a vector first presented at cycle t is sampled at the edge ending cycle t+SETTLE. observed and covered update on that same edge.
- A final sample that completes coverage sets done and pass on the next edge. busy drops on that same edge.
- If the timeout and the final sample land on the same cycle, coverage wins and timed_out stays 0.
- A vector held for fewer than SETTLE+1 cycles is never sampled (glitch rejection).
- A start arriving on the cycle the FSM enters DONE is ignored. start must be reasserted while in DONE to begin a new run.

## Configuration
- TT_FIRST_FAIL_EN defined:
  - Adds outputs first_fail_vec [N_IN-1:0] and first_fail_valid [1].
  - first_fail_vec captures the idx of the first mismatching sample in the run; first_fail_valid is set with it.
  - Both are cleared on run start and on rst.
- TT_FIRST_FAIL_EN undefined: these ports and registers are absent. All other behaviour is identical.

## Structure
- Shared package or header tt_pkg holds:
  - the state encoding (IDLE=2'd0, CAPTURE=2'd1, DONE=2'd2);
  - the MISMATCH_W=8 constant;
  - the default majority table constant.
- One natural sub-module: tt_stability_filter (prev_vec, stab_cnt, sample strobe), parameterised by N_IN and SETTLE.
- FSM, table registers and counters live in the top level.

## Test plan
- Majority DUT, all 8 vectors in order, each held 4 cycles -> covered=8'hFF, observed=8'hE8, mismatch_cnt=0, done=1, pass=1.
- Same stimulus but y forced to 1 at idx 3'b001 -> mismatch_cnt=1, pass=0, first_fail_vec=3'b001 with the macro defined.
- Vector 3'b101 held for 2 cycles with SETTLE=2 -> covered[5] stays 0. Holding it for 3 cycles -> covered[5]=1.
- idx 3'b110 sampled with y=1, then sampled again with y=0 -> conflict=1, pass=0, observed[6]=0.
- Only 7 vectors driven, TIMEOUT=40 -> done at cycle 40, timed_out=1, pass=0, covered=8'h7F.
- rst asserted after 4 samples -> all outputs 0, state IDLE. A new start then captures a clean full run with pass=1.
